// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers used by the key
// expander and the decryption core.
package aes_pkg;

    localparam int NK     = 8;
    localparam int NR     = 14;
    localparam int NB     = 4;
    localparam int WORD_W = 32;
    localparam int RK_W   = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Index 0 is never used; AES-256 only needs Rcon[1..7].
    localparam logic [7:0] RCON [0:7] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of a, 2a, 4a, 8a are summed (k=4'he -> 0x0e * a).
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = gf_mul_const(a0, 4'he) ^ gf_mul_const(a1, 4'hb) ^ gf_mul_const(a2, 4'hd) ^ gf_mul_const(a3, 4'h9);
        b1 = gf_mul_const(a0, 4'h9) ^ gf_mul_const(a1, 4'he) ^ gf_mul_const(a2, 4'hb) ^ gf_mul_const(a3, 4'hd);
        b2 = gf_mul_const(a0, 4'hd) ^ gf_mul_const(a1, 4'h9) ^ gf_mul_const(a2, 4'he) ^ gf_mul_const(a3, 4'hb);
        b3 = gf_mul_const(a0, 4'hb) ^ gf_mul_const(a1, 4'hd) ^ gf_mul_const(a2, 4'h9) ^ gf_mul_const(a3, 4'he);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes256_key_expander.sv
// Iterative AES-256 key schedule: one word per clock into a 15-entry round-key buffer.
// Define AES_EQ_INV_KEYS_EN to return InvMixColumns(rk) for indices 1..13.
//
//  state  | meaning
//  IDLE   | no valid keys, waiting for start
//  EXPAND | producing w8..w59, one word per edge
//  DONE   | all round keys valid, start restarts expansion
module aes256_key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:255] key_in,
    output logic         busy,
    output logic         ready,
    input  logic [0:3]   rd_addr,
    output logic [0:127] rd_key
);

    state_t        state, state_nxt;
    logic [5:0]    word_idx;
    logic [31:0]   win [0:7];
    logic [127:0]  rk  [0:NR];
    logic          load, step, last;
    logic [31:0]   prev, sub_in, sub_out, temp, w_new;
    logic [3:0]    rk_sel;

    assign prev   = win[7];
    assign sub_in = (word_idx[2:0] == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .a (sub_in[8*g +: 8]),
            .y (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (word_idx[2:0] == 3'd0)
            temp = sub_out ^ {RCON[word_idx[5:3]], 24'h0};
        else if (word_idx[2:0] == 3'd4)
            temp = sub_out;
    end

    assign w_new  = win[0] ^ temp;
    assign rk_sel = word_idx[5:2];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (word_idx == 6'd59) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ready    <= 1'b0;
            word_idx <= 6'd0;
        end else begin
            state <= state_nxt;
            if (load) begin
                busy     <= 1'b1;
                ready    <= 1'b0;
                word_idx <= 6'd8;
            end else if (step) begin
                word_idx <= (word_idx == 6'd60) ? 6'd60 : word_idx + 6'd1;
                if (last) begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            end
        end
    end

    // Key storage needs no reset: ready=0 already marks it invalid.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NK; k++)
                win[k] <= key_in[32*k +: 32];
            rk[0] <= key_in[0:127];
            rk[1] <= key_in[128:255];
        end else if (step) begin
            for (int k = 0; k < NK - 1; k++)
                win[k] <= win[k+1];
            win[7] <= w_new;
            case (word_idx[1:0])
                2'd0: rk[rk_sel][127:96] <= w_new;
                2'd1: rk[rk_sel][95:64]  <= w_new;
                2'd2: rk[rk_sel][63:32]  <= w_new;
                default: rk[rk_sel][31:0] <= w_new;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_key <= '0;
        else if (rd_addr == 4'd15)
            rd_key <= '0;
`ifdef AES_EQ_INV_KEYS_EN
        else if (rd_addr != 4'd0 && rd_addr != 4'd14)
            rd_key <= inv_mix_columns(rk[rd_addr]);
`endif
        else
            rd_key <= rk[rd_addr];
    end

endmodule
